// File: rtl/isp_stream_scheduler.sv
// Per-pipeline frame sequencer between the CSI-2 header decoder and the ISP pipelines.
// Optional feature macro: ISP_SCHED_ERR_CNT_EN enables the drop / DT-mismatch counters.
module isp_stream_scheduler #(
  parameter int PIPELINE_WIDTH = 4
) (
  input  logic                           byte_clk_i,
  input  logic                           byte_reset_i,
  input  logic [PIPELINE_WIDTH-1:0]      enable_reg_i,
  input  logic [PIPELINE_WIDTH-1:0][1:0] vc_reg_i,
  input  logic [PIPELINE_WIDTH-1:0][5:0] data_type_reg_i,
  input  logic                           header_valid_i,
  input  logic [1:0]                     header_vc_i,
  input  logic [5:0]                     header_dt_i,
  input  logic                           payload_active_i,
  input  logic [PIPELINE_WIDTH-1:0]      frame_done_i,
  output logic [3:0]                     activate_stream_o,
  output logic [PIPELINE_WIDTH-1:0]      frame_valid_o,
  output logic [PIPELINE_WIDTH-1:0]      line_valid_o,
  output logic [PIPELINE_WIDTH-1:0]      busy_o,
  output logic [PIPELINE_WIDTH-1:0][7:0] frame_drop_cnt_o,
  output logic [PIPELINE_WIDTH-1:0][7:0] dt_mismatch_cnt_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, SKIP} state_t;

  logic                      hdr_fs, hdr_fe, hdr_long;
  logic [PIPELINE_WIDTH-1:0] cand;
  logic [PIPELINE_WIDTH-1:0] sel_next;
  logic [PIPELINE_WIDTH-1:0] act_reg;
  logic                      payload_active_reg;

  assign hdr_fs   = header_valid_i && (header_dt_i == 6'h00);
  assign hdr_fe   = header_valid_i && (header_dt_i == 6'h01);
  assign hdr_long = header_valid_i && (header_dt_i >= 6'h10);

  for (genvar gi = 0; gi < PIPELINE_WIDTH; gi++) begin : g_pipe
    state_t      state_reg;
    logic        done_seen_reg;
    logic [1:0]  vc_lat_reg;
    logic [5:0]  dt_lat_reg;
    logic        frame_valid_reg;
    logic        busy_reg;
    logic        live_match;
    logic        lat_match;
    logic        done;

    // Live config only matters when a frame is accepted; afterwards the latched VC/DT rule.
    assign live_match = enable_reg_i[gi] && (vc_reg_i[gi] == header_vc_i);
    assign lat_match  = (header_vc_i == vc_lat_reg);
    assign done       = frame_done_i[gi];
    assign cand[gi]   = (state_reg == ACTIVE) && hdr_long && lat_match &&
                        (header_dt_i == dt_lat_reg);

    always_ff @(posedge byte_clk_i) begin
      if (byte_reset_i) begin
        state_reg       <= IDLE;
        done_seen_reg   <= 1'b0;
        vc_lat_reg      <= 2'd0;
        dt_lat_reg      <= 6'd0;
        frame_valid_reg <= 1'b0;
        busy_reg        <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (hdr_fs && live_match) begin
              vc_lat_reg      <= vc_reg_i[gi];
              dt_lat_reg      <= data_type_reg_i[gi];
              frame_valid_reg <= 1'b1;
              busy_reg        <= 1'b1;
              state_reg       <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (hdr_fs && lat_match) begin
              frame_valid_reg <= 1'b0;
              done_seen_reg   <= 1'b0;
              state_reg       <= SKIP;
            end else if (hdr_fe && lat_match) begin
              frame_valid_reg <= 1'b0;
              state_reg       <= DRAIN;
            end
          end
          DRAIN: begin
            if (done) begin
              // Done wins over a simultaneous FS, which is then accepted as a fresh frame.
              if (hdr_fs && live_match) begin
                vc_lat_reg      <= vc_reg_i[gi];
                dt_lat_reg      <= data_type_reg_i[gi];
                frame_valid_reg <= 1'b1;
                state_reg       <= ACTIVE;
              end else begin
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end
            end else if (hdr_fs && lat_match) begin
              done_seen_reg <= 1'b0;
              state_reg     <= SKIP;
            end
          end
          SKIP: begin
            if (hdr_fe && lat_match) begin
              done_seen_reg <= 1'b0;
              if (done_seen_reg || done) begin
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end else begin
                state_reg <= DRAIN;
              end
            end else if (done) begin
              done_seen_reg <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end

    assign frame_valid_o[gi] = frame_valid_reg;
    assign busy_o[gi]        = busy_reg;

`ifdef ISP_SCHED_ERR_CNT_EN
    logic       drop_evt, mis_evt;
    logic [7:0] drop_cnt_reg, mis_cnt_reg;

    assign drop_evt = hdr_fs && lat_match &&
                      ((state_reg == ACTIVE) || ((state_reg == DRAIN) && !done));
    assign mis_evt  = (state_reg == ACTIVE) && hdr_long && lat_match &&
                      (header_dt_i != dt_lat_reg);

    always_ff @(posedge byte_clk_i) begin
      if (byte_reset_i) begin
        drop_cnt_reg <= 8'd0;
        mis_cnt_reg  <= 8'd0;
      end else begin
        if (drop_evt && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
        if (mis_evt && (mis_cnt_reg != 8'hFF))   mis_cnt_reg  <= mis_cnt_reg + 8'd1;
      end
    end

    assign frame_drop_cnt_o[gi]  = drop_cnt_reg;
    assign dt_mismatch_cnt_o[gi] = mis_cnt_reg;
`else
    assign frame_drop_cnt_o[gi]  = 8'd0;
    assign dt_mismatch_cnt_o[gi] = 8'd0;
`endif
  end

  // Lowest-index candidate wins the payload.
  always_comb begin
    sel_next = '0;
    for (int i = PIPELINE_WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_next    = '0;
        sel_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge byte_clk_i) begin
    if (byte_reset_i) begin
      act_reg            <= '0;
      payload_active_reg <= 1'b0;
    end else begin
      payload_active_reg <= payload_active_i;
      if (header_valid_i) begin
        act_reg <= sel_next;
      end else if (payload_active_reg && !payload_active_i) begin
        act_reg <= '0;
      end
    end
  end

  assign line_valid_o = act_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_act
    if (gi < PIPELINE_WIDTH) begin : g_used
      assign activate_stream_o[gi] = act_reg[gi];
    end else begin : g_tied
      assign activate_stream_o[gi] = 1'b0;
    end
  end

endmodule
